speaker_sched: RTL
==================

// Module: speaker_sched
// PURPOSE
// - Schedules the single speaker output. Requesters are: live lamp tone (LAMP/LAMP_ENA from controller),
//   WIN, LOSE and HS jingles. Sits beside controller in tt_um_iron_violet_simon.
// - Decides which source owns the tone generator, sequences multi-note jingles from ROM, drives square wave.
// PARAMETERS
// - CLK_FREQ_HZ  50_000_000  clock frequency; tone half-period = floor(CLK_FREQ_HZ / (2*freq_hz))
// - NOTE_MS      150         duration of one jingle note, ms (NOTE_CYC = CLK_FREQ_HZ/1000*NOTE_MS)
// - GAP_MS       30          silence after each jingle note, ms (GAP_CYC likewise)
// PORTS
// - CLK       in   1  clock
// - RST       in   1  synchronous reset, active-high
// - LAMP      in   2  lamp index from controller (0..3)
// - LAMP_ENA  in   1  lamp lit; requests lamp tone while high
// - WIN       in   1  level; a 0->1 edge requests WIN jingle
// - LOSE      in   1  level; a 0->1 edge requests LOSE jingle
// - HS        in   1  level; a 0->1 edge requests HS jingle
// - SPKR      out  1  square-wave speaker drive
// - BUSY      out  1  high while any jingle is playing or pending
// BEHAVIOUR
// - Reset: SPKR=0, BUSY=0, state=IDLE, pending=3'b000, note/gap/tone counters=0, edge-detect prev regs=1
//   (a level already high at reset release requests nothing; only a true 0->1 edge requests).
// - Note table NOTE_HZ[0..7] = {209,252,310,415,523,659,784,110}. Lamp i plays note i.
// - Jingle ROMs (note index lists): WIN={4,5,6,6}; HS={4,5,6,4,5,6}; LOSE={7,7,7}. Max length 8.
// - Edge detection is registered: edge seen on input in cycle N sets pending bit in N+1.
// - Priority LOSE > WIN > HS > lamp tone.
// - States: IDLE, LAMP_TONE, J_NOTE, J_GAP.
//   IDLE: pending!=0 -> J_NOTE with highest-priority pending jingle, its bit cleared, idx=0;
//         else LAMP_ENA -> LAMP_TONE; else stay, SPKR held 0.
//   LAMP_TONE: tone = NOTE_HZ[LAMP]; LAMP change restarts tone counter with SPKR=0;
//              LAMP_ENA low -> IDLE; pending!=0 -> IDLE (jingle preempts lamp same cycle as IDLE rules).
//   J_NOTE: tone = ROM[idx]; after NOTE_CYC cycles -> J_GAP, SPKR=0.
//   J_GAP: SPKR=0; after GAP_CYC cycles idx+1; idx==len -> IDLE, else J_NOTE.
// - Tone: half-period counter; SPKR forced 0 on every note/state entry, first toggle after HALF cycles.
// - Preemption: edge of a strictly higher-priority jingle during J_NOTE/J_GAP aborts the current jingle
//   immediately (not resumed) and starts the new one at idx=0 next cycle.
// - Lower-priority edges during a jingle set pending and play afterwards in priority order.
// - Edge of the jingle currently playing is ignored (no retrigger, no pending set).
// - Simultaneous edges: all pending bits set; highest plays first, rest follow; e.g. WIN+HS -> WIN then HS.
// - Lamp requests during J_NOTE/J_GAP are muted, not queued.
// - BUSY = (state in {J_NOTE,J_GAP}) | (pending!=0).
// - RST mid-jingle: everything returns to reset values next cycle; pending cleared.
// - Counter widths: $clog2 of max(NOTE_CYC,GAP_CYC,max half-period)+1; no wrap beyond terminal count.
// STRUCTURE
// - speaker_pkg: state enum, NOTE_HZ table, jingle ROMs + lengths, jingle id enum (J_LOSE/J_WIN/J_HS).
// - Sub-module tone_gen: loadable half-period counter + SPKR toggle flop, inputs CLK, RST, restart, half.
// - speaker_sched: edge detect, pending register, priority select, FSM, note/gap counters.
// TESTING (CLK_FREQ_HZ=100_000, NOTE_MS=10, GAP_MS=2 -> NOTE_CYC=1000, GAP_CYC=200)
// - Reset, hold WIN/LOSE/HS high through release -> no jingle, SPKR=0, BUSY=0 for 5000 cycles.
// - LAMP=0, LAMP_ENA=1 -> SPKR toggles every 239 cycles; LAMP->3 -> SPKR=0 then 120-cycle half-period (415 Hz).
// - WIN pulse -> BUSY next cycle; notes 95,75,63,63 half-periods, each 1000 cyc + 200 gap; BUSY low after 4800.
// - WIN during HS note 2 -> HS aborted, WIN plays from idx 0; HS not resumed; total WIN 4800 cycles.
// - WIN and HS same cycle -> WIN (4800) then HS (7200) back to back; LAMP_ENA asserted meanwhile stays muted.
// - LOSE during WIN then RST mid-LOSE -> SPKR=0, BUSY=0 next cycle; pending WIN/HS discarded.

Source files
------------

// File: rtl/speaker_pkg.sv
// Shared types and constant tables for the speaker scheduler:
// FSM states, jingle identifiers, note frequencies and jingle note ROMs.
package speaker_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LAMP_TONE, S_J_NOTE, S_J_GAP} state_t;

  // Numeric value doubles as priority and as the pending-bit index.
  typedef enum logic [1:0] {J_HS = 2'd0, J_WIN = 2'd1, J_LOSE = 2'd2} jingle_t;

  localparam int unsigned NOTE_HZ [8] = '{209, 252, 310, 415, 523, 659, 784, 110};

  localparam logic [2:0] WIN_ROM  [8] = '{3'd4, 3'd5, 3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
  localparam logic [2:0] HS_ROM   [8] = '{3'd4, 3'd5, 3'd6, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};
  localparam logic [2:0] LOSE_ROM [8] = '{3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

  function automatic logic [3:0] jingle_len(jingle_t j);
    case (j)
      J_WIN:   return 4'd4;
      J_HS:    return 4'd6;
      J_LOSE:  return 4'd3;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] jingle_note(jingle_t j, logic [2:0] idx);
    case (j)
      J_WIN:   return WIN_ROM[idx];
      J_HS:    return HS_ROM[idx];
      J_LOSE:  return LOSE_ROM[idx];
      default: return 3'd0;
    endcase
  endfunction

  function automatic int unsigned half_period(int unsigned clk_hz, logic [2:0] n);
    return clk_hz / (2 * NOTE_HZ[n]);
  endfunction

  function automatic int unsigned max_half(int unsigned clk_hz);
    int unsigned m = 0;
    for (int i = 0; i < 8; i++)
      if (half_period(clk_hz, 3'(i)) > m) m = half_period(clk_hz, 3'(i));
    return m;
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: a loadable half-period counter driving a toggle flop.
// restart clears the counter and forces the output low; first toggle follows HALF cycles later.
module tone_gen #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         restart,
  input  logic [W-1:0] half,
  output logic         spkr
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST || restart) begin
      cnt  <= '0;
      spkr <= 1'b0;
    end else if (cnt == half - W'(1)) begin
      cnt  <= '0;
      spkr <= ~spkr;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/speaker_sched.sv
// Speaker owner arbitration: lamp tone vs. WIN/LOSE/HS jingles, with edge-triggered
// requests, a pending queue resolved by priority, and preemption by higher jingles.
module speaker_sched
  import speaker_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned NOTE_MS     = 150,
  parameter int unsigned GAP_MS      = 30
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] LAMP,
  input  logic       LAMP_ENA,
  input  logic       WIN,
  input  logic       LOSE,
  input  logic       HS,
  output logic       SPKR,
  output logic       BUSY
);

  localparam int unsigned NOTE_CYC = CLK_FREQ_HZ / 1000 * NOTE_MS;
  localparam int unsigned GAP_CYC  = CLK_FREQ_HZ / 1000 * GAP_MS;
  localparam int unsigned CNT_MAX  = max_u(max_u(NOTE_CYC, GAP_CYC), max_half(CLK_FREQ_HZ));
  localparam int          CW       = $clog2(CNT_MAX + 1);

  localparam int unsigned HALF_TAB [8] = '{
    half_period(CLK_FREQ_HZ, 3'd0), half_period(CLK_FREQ_HZ, 3'd1),
    half_period(CLK_FREQ_HZ, 3'd2), half_period(CLK_FREQ_HZ, 3'd3),
    half_period(CLK_FREQ_HZ, 3'd4), half_period(CLK_FREQ_HZ, 3'd5),
    half_period(CLK_FREQ_HZ, 3'd6), half_period(CLK_FREQ_HZ, 3'd7)};

  state_t        state;
  jingle_t       cur;
  logic [3:0]    idx;
  logic [CW-1:0] dur_cnt;
  logic [2:0]    pending;
  logic          win_q, lose_q, hs_q;
  logic [1:0]    lamp_q;

  logic [2:0]    edges, cur_mask, clr_mask;
  logic          in_jingle, has_pend, preempt, start, note_done, gap_done, lamp_chg, restart;
  jingle_t       top_j;
  logic [3:0]    idx_next;
  logic [2:0]    tone_note;
  logic [CW-1:0] half;

  assign edges     = {LOSE & ~lose_q, WIN & ~win_q, HS & ~hs_q};
  assign in_jingle = (state == S_J_NOTE) || (state == S_J_GAP);
  // The playing jingle masks its own edges, so it neither retriggers nor queues itself.
  assign cur_mask  = in_jingle ? (3'b001 << cur) : 3'b000;
  assign has_pend  = |pending;
  assign top_j     = pending[2] ? J_LOSE : (pending[1] ? J_WIN : J_HS);
  assign preempt   = in_jingle && has_pend && (top_j > cur);
  assign start     = ((state == S_IDLE) && has_pend) || preempt;
  assign clr_mask  = start ? (3'b001 << top_j) : 3'b000;
  assign note_done = dur_cnt == CW'(NOTE_CYC - 1);
  assign gap_done  = dur_cnt == CW'(GAP_CYC - 1);
  assign lamp_chg  = LAMP != lamp_q;
  assign idx_next  = idx + 4'd1;

  assign tone_note = (state == S_LAMP_TONE) ? LAMP : jingle_note(cur, idx[2:0]);
  assign half      = CW'(HALF_TAB[tone_note]);

  // Held in restart whenever silent, so any entry into a tone state starts from SPKR=0.
  assign restart = ((state != S_LAMP_TONE) && (state != S_J_NOTE))
                || ((state == S_LAMP_TONE) && (lamp_chg || !LAMP_ENA || has_pend))
                || ((state == S_J_NOTE) && note_done)
                || preempt;

  assign BUSY = in_jingle || has_pend;

  tone_gen #(.W(CW)) u_tone (
    .CLK     (CLK),
    .RST     (RST),
    .restart (restart),
    .half    (half),
    .spkr    (SPKR)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cur     <= J_HS;
      idx     <= '0;
      dur_cnt <= '0;
      pending <= '0;
      // Prev regs start high so a level already asserted at release is not an edge.
      win_q   <= 1'b1;
      lose_q  <= 1'b1;
      hs_q    <= 1'b1;
      lamp_q  <= '0;
    end else begin
      {lose_q, win_q, hs_q} <= {LOSE, WIN, HS};
      lamp_q  <= LAMP;
      pending <= (pending & ~clr_mask) | (edges & ~cur_mask);
      if (start) begin
        state   <= S_J_NOTE;
        cur     <= top_j;
        idx     <= '0;
        dur_cnt <= '0;
      end else begin
        case (state)
          S_IDLE:      if (LAMP_ENA) state <= S_LAMP_TONE;
          S_LAMP_TONE: if (!LAMP_ENA || has_pend) state <= S_IDLE;
          S_J_NOTE: begin
            if (note_done) begin
              state   <= S_J_GAP;
              dur_cnt <= '0;
            end else begin
              dur_cnt <= dur_cnt + CW'(1);
            end
          end
          S_J_GAP: begin
            if (gap_done) begin
              dur_cnt <= '0;
              idx     <= idx_next;
              state   <= (idx_next == jingle_len(cur)) ? S_IDLE : S_J_NOTE;
            end else begin
              dur_cnt <= dur_cnt + CW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
